// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
//   state_t          - transmitter FSM encoding (IDLE, START, DATA, STOP)
//   DEF_DBIT         - default data bits per frame
//   DEF_SB_TICK      - default oversample ticks in the stop period
//   DEF_DVSR         - default clk cycles per oversample tick
//   BIT_TICKS        - oversample ticks per start/data bit
//   width_of()       - counter width able to hold 0..n-1 (never below 1)
package fifo_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;
    localparam int DEF_DVSR    = 163;
    localparam int BIT_TICKS   = 16;

    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Pop-side handshake of a first-word-fall-through FIFO.
//   fifo_empty - FIFO has no word at its head
//   fifo_data  - head word, valid while fifo_empty is low
//   fifo_rd    - one-cycle pop strobe
// master: the consumer that pops (the transmitter); slave: the FIFO.
interface fifo_uart_tx_if
    import fifo_uart_tx_pkg::*;
#(
    parameter int DBIT = DEF_DBIT
) ();

    logic            fifo_empty;
    logic [DBIT-1:0] fifo_data;
    logic            fifo_rd;

    modport master (input  fifo_empty, input  fifo_data, output fifo_rd);
    modport slave  (output fifo_empty, output fifo_data, input  fifo_rd);

endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Oversample tick generator: counts 0..DVSR-1 and pulses tick_o for one
// cycle at DVSR-1 before wrapping. clr_i restarts the count at 0 on the
// next edge so a frame's bit periods are aligned to its start.
//   clk, reset - clock, asynchronous active-high reset
//   clr_i      - synchronous counter clear
//   tick_o     - one-cycle oversample tick
module baud_gen
    import fifo_uart_tx_pkg::*;
#(
    parameter int DVSR = DEF_DVSR
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);

    localparam int            C_W  = width_of(DVSR);
    localparam logic [C_W-1:0] LAST = C_W'(DVSR - 1);

    logic [C_W-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clr_i || cnt_q == LAST) cnt_d = '0;
        else                        cnt_d = cnt_q + 1'b1;
    end

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from an upstream FWFT FIFO and sends
// each as start bit, DBIT data bits LSB first, and a SB_TICK-tick stop
// period. The word is popped in IDLE and captured in the same cycle, so
// FIFO activity during a frame never affects it.
//   clk, reset   - clock, asynchronous active-high reset
//   fifo         - FIFO pop handshake (master side)
//   tx           - registered serial line, idle high
//   tx_busy      - high whenever a frame is in progress
//   tx_done_tick - one-cycle pulse at the end of the stop period
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK,
    parameter int DVSR    = DEF_DVSR
) (
    input  logic         clk,
    input  logic         reset,
    fifo_uart_tx_if.master fifo,
    output logic         tx,
    output logic         tx_busy,
    output logic         tx_done_tick
);

    localparam int S_W = width_of((SB_TICK > BIT_TICKS) ? SB_TICK : BIT_TICKS);
    localparam int N_W = width_of(DBIT);

    localparam logic [S_W-1:0] LAST_BIT_TICK  = S_W'(BIT_TICKS - 1);
    localparam logic [S_W-1:0] LAST_STOP_TICK = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] LAST_BIT       = N_W'(DBIT - 1);

    state_t          state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;      // oversample ticks within current bit
    logic [N_W-1:0]  n_q, n_d;      // data bit index
    logic [DBIT-1:0] b_q, b_d;      // shift register, LSB is on the line
    logic            tx_q, tx_d;
    logic            tick;
    logic            start;

    // Pop is held off while reset is asserted so the FIFO loses no word.
    assign start        = (state_q == IDLE) && !fifo.fifo_empty && !reset;
    assign fifo.fifo_rd = start;

    baud_gen #(.DVSR(DVSR)) u_baud_gen (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (start),
        .tick_o (tick)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case statement can infer a latch.
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        tx_done_tick = 1'b0;
        tx_d         = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                    s_d     = '0;
                    n_d     = '0;
                    b_d     = fifo.fifo_data;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == LAST_BIT_TICK) begin
                        state_d = DATA;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == LAST_BIT_TICK) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == LAST_BIT) state_d = STOP;
                        else                 n_d     = n_q + 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == LAST_STOP_TICK) begin
                        state_d      = IDLE;
                        tx_done_tick = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state, so the registered tx lines up
        // with the state register instead of lagging it by a cycle.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // NOTE: only control and datapath flops are reset here; there is no
    // storage array, so every register returns to a defined value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with DVSR=2: one bit = 32 clk, frame =
// 320 clk. Outputs are sampled 1 ns after the falling clock edge.
module tb_fifo_uart_tx;
    import fifo_uart_tx_pkg::*;

    localparam int DBIT      = 8;
    localparam int SB_TICK   = 16;
    localparam int DVSR      = 2;
    localparam int BIT_CLK   = 32;
    localparam int FRAME_CLK = 320;

    logic clk = 1'b0;
    logic reset;
    logic tx, tx_busy, tx_done_tick;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_uart_tx_if #(.DBIT(DBIT)) fifo_bus ();

    fifo_uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR(DVSR)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo         (fifo_bus),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rd(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (fifo_bus.fifo_rd === 1'b1) begin
                found = 1'b1;
                break;
            end
            sample();
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL %s wait_rd: fifo_rd never seen within 40 clk, expected 1", name);
        end
    endtask

    // Entered at the sample point of the cycle where fifo_rd is high.
    // Applies the next FIFO state after the pop edge, then checks the 320
    // frame cycles and the first IDLE cycle that follows.
    task automatic check_frame(input string name, input logic [7:0] exp,
                               input logic nxt_empty, input logic [7:0] nxt_data,
                               input bit wiggle, input logic exp_rd_after);
        logic [9:0] bad_bit = '0;
        logic [9:0] act_bit = '0;
        int  done_at = -1;
        int  done_cnt = 0;
        bit  rd_bad = 1'b0, busy_bad = 1'b0;
        logic exp_tx;
        int  idx;

        @(posedge clk);
        #1;
        fifo_bus.fifo_empty = nxt_empty;
        fifo_bus.fifo_data  = nxt_data;

        for (int k = 1; k <= FRAME_CLK; k++) begin
            sample();
            idx = (k - 1) / BIT_CLK;
            if (idx == 0)      exp_tx = 1'b0;
            else if (idx == 9) exp_tx = 1'b1;
            else               exp_tx = exp[idx-1];
            if (tx !== exp_tx && !bad_bit[idx]) begin
                bad_bit[idx] = 1'b1;
                act_bit[idx] = tx;
            end
            if (tx_done_tick === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (fifo_bus.fifo_rd !== 1'b0) rd_bad = 1'b1;
            if (tx_busy !== 1'b1)          busy_bad = 1'b1;
            if (wiggle) begin
                case (k)
                    100: begin fifo_bus.fifo_empty = 1'b0; fifo_bus.fifo_data = 8'hFF; end
                    200: begin fifo_bus.fifo_empty = 1'b1; fifo_bus.fifo_data = 8'h00; end
                    250: begin fifo_bus.fifo_empty = 1'b0; fifo_bus.fifo_data = 8'h81; end
                    319: begin fifo_bus.fifo_empty = nxt_empty; fifo_bus.fifo_data = nxt_data; end
                    default: ;
                endcase
            end
        end

        for (int b = 0; b < 10; b++) begin
            n_cmp++;
            if (bad_bit[b]) begin
                n_bad++;
                $display("FAIL %s bit_slot%0d: tx=%b seen, expected %b for all 32 clk", name, b,
                         act_bit[b], ~act_bit[b]);
            end
        end
        n_cmp++;
        if (done_at !== FRAME_CLK || done_cnt !== 1) begin
            n_bad++;
            $display("FAIL %s done_tick: first at clk %0d (%0d pulses), expected clk %0d (1 pulse)",
                     name, done_at, done_cnt, FRAME_CLK);
        end
        n_cmp++;
        if (rd_bad) begin
            n_bad++;
            $display("FAIL %s rd_in_frame: fifo_rd=1 during frame, expected 0", name);
        end
        n_cmp++;
        if (busy_bad) begin
            n_bad++;
            $display("FAIL %s busy_in_frame: tx_busy=0 during frame, expected 1", name);
        end

        sample();   // clk 321 after the pop: first IDLE cycle
        n_cmp++;
        if (fifo_bus.fifo_rd !== exp_rd_after) begin
            n_bad++;
            $display("FAIL %s rd_after: fifo_rd=%b, expected %b", name, fifo_bus.fifo_rd, exp_rd_after);
        end
        n_cmp++;
        if (tx_busy !== 1'b0 || tx !== 1'b1) begin
            n_bad++;
            $display("FAIL %s idle_after: tx_busy=%b tx=%b, expected 0 1", name, tx_busy, tx);
        end
    endtask

    task automatic test_reset();
        reset               = 1'b1;
        fifo_bus.fifo_empty = 1'b0;
        fifo_bus.fifo_data  = 8'hA5;
        #2;
        n_cmp++;
        if ({tx, tx_busy, tx_done_tick, fifo_bus.fifo_rd} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_async: tx/busy/done/rd=%b, expected 1000",
                     {tx, tx_busy, tx_done_tick, fifo_bus.fifo_rd});
        end
        repeat (3) sample();
        n_cmp++;
        if ({tx, tx_busy, tx_done_tick, fifo_bus.fifo_rd} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_held: tx/busy/done/rd=%b, expected 1000",
                     {tx, tx_busy, tx_done_tick, fifo_bus.fifo_rd});
        end
        fifo_bus.fifo_empty = 1'b1;
        reset               = 1'b0;
    endtask

    task automatic test_idle_empty();
        bit tx_bad = 1'b0, rd_bad = 1'b0, busy_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            sample();
            if (tx !== 1'b1)               tx_bad = 1'b1;
            if (fifo_bus.fifo_rd !== 1'b0) rd_bad = 1'b1;
            if (tx_busy !== 1'b0)          busy_bad = 1'b1;
        end
        n_cmp++;
        if (tx_bad) begin n_bad++; $display("FAIL idle_tx: tx=0 seen while empty, expected 1"); end
        n_cmp++;
        if (rd_bad) begin n_bad++; $display("FAIL idle_rd: fifo_rd=1 seen while empty, expected 0"); end
        n_cmp++;
        if (busy_bad) begin n_bad++; $display("FAIL idle_busy: tx_busy=1 seen while empty, expected 0"); end
    endtask

    task automatic test_single();
        fifo_bus.fifo_data  = 8'hA5;
        fifo_bus.fifo_empty = 1'b0;
        #1;
        wait_rd("single");
        check_frame("single_A5", 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        sample();
        fifo_bus.fifo_data  = 8'h0F;
        fifo_bus.fifo_empty = 1'b0;
        #1;
        wait_rd("b2b");
        check_frame("b2b_0F", 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b1);
        check_frame("b2b_F0", 8'hF0, 1'b0, 8'h55, 1'b0, 1'b1);
        check_frame("b2b_55", 8'h55, 1'b1, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        bit rd_bad = 1'b0, tx_bad = 1'b0;
        sample();
        fifo_bus.fifo_data  = 8'hFF;
        fifo_bus.fifo_empty = 1'b0;
        #1;
        wait_rd("rst_mid");
        @(posedge clk);
        #1;
        fifo_bus.fifo_empty = 1'b1;
        repeat (100) sample();      // well inside DATA
        n_cmp++;
        if (tx_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_busy: tx_busy=%b before reset, expected 1", tx_busy);
        end
        reset = 1'b1;
        #1;                         // no clock edge between assertion and check
        n_cmp++;
        if ({tx, tx_busy, tx_done_tick, fifo_bus.fifo_rd} !== 4'b1000) begin
            n_bad++;
            $display("FAIL rst_mid_async: tx/busy/done/rd=%b, expected 1000",
                     {tx, tx_busy, tx_done_tick, fifo_bus.fifo_rd});
        end
        repeat (2) sample();
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            sample();
            if (fifo_bus.fifo_rd !== 1'b0) rd_bad = 1'b1;
            if (tx !== 1'b1 || tx_busy !== 1'b0) tx_bad = 1'b1;
        end
        n_cmp++;
        if (rd_bad) begin n_bad++; $display("FAIL rst_mid_no_reread: fifo_rd=1 while empty, expected 0"); end
        n_cmp++;
        if (tx_bad) begin n_bad++; $display("FAIL rst_mid_idle: tx/busy left idle after reset, expected 1/0"); end
        fifo_bus.fifo_data  = 8'h3C;
        fifo_bus.fifo_empty = 1'b0;
        #1;
        n_cmp++;
        if (fifo_bus.fifo_rd !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_resume: fifo_rd=%b once non-empty, expected 1", fifo_bus.fifo_rd);
        end
    endtask

    task automatic test_fifo_ignored();
        // Entered with 8'h3C at the FIFO head and fifo_rd already high.
        wait_rd("ignore");
        check_frame("ignore_3C", 8'h3C, 1'b1, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle_empty();
        test_single();
        test_back_to_back();
        test_reset_mid_frame();
        test_fifo_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
